// File: rtl/data_mem_unit_if.sv
// Bus between the CPU pipeline (master) and the data-memory stage (slave).
// Carries the load/store request, store data and the combinational/registered
// status returned by the memory.
interface data_mem_unit_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_read;
  logic        mem_write;
  logic [1:0]  size;
  logic        ld_uns;
  logic [31:0] rdata;
  logic        busy;
  logic        misalign;
  logic        oob;
  logic        err_sticky;

  modport master (
    output addr, wdata, mem_read, mem_write, size, ld_uns,
    input  rdata, busy, misalign, oob, err_sticky
  );

  modport slave (
    input  addr, wdata, mem_read, mem_write, size, ld_uns,
    output rdata, busy, misalign, oob, err_sticky
  );
endinterface

// File: rtl/data_mem_unit.sv
// Data-memory stage for MIPS lw/lh/lhu/lb/lbu/sw/sh/sb.
// Little-endian byte lanes, synchronous writes, combinational reads.
// After reset an FSM zero-fills every word (one per cycle) before any access
// is honoured; busy stalls the CPU meanwhile.
module data_mem_unit #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = 8
) (
  input  logic            clk,
  input  logic            reset,
  data_mem_unit_if.slave  bus
);

  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH_WORDS - 1);

  state_t        state_q, state_d;
  logic [AW-1:0] clr_ptr_q, clr_ptr_d;
  logic          err_sticky_q, err_sticky_d;

  logic [31:0]   mem_q [DEPTH_WORDS];

  logic          req_s;
  logic          misalign_s;
  logic          oob_s;
  logic          rejected_s;
  logic          store_s;
  logic [AW-1:0] idx_s;
  logic [1:0]    lane_s;
  logic [31:0]   rd_word_s;
  logic [7:0]    byte_s;
  logic [15:0]   half_s;
  logic          ext_s;
  logic [31:0]   rdata_s;
  logic [3:0]    be_s;
  logic [31:0]   wd_s;

  // Requests are only seen once the fill has completed.
  assign req_s     = (bus.mem_read | bus.mem_write) & (state_q == ST_READY);
  assign idx_s     = bus.addr[AW+1:2];
  assign lane_s    = bus.addr[1:0];
  assign rd_word_s = mem_q[idx_s];

  // Alignment / range checks on an active request.
  always_comb begin
    misalign_s = 1'b0;
    oob_s      = 1'b0;
    if (req_s) begin
      case (bus.size)
        2'b00:   misalign_s = 1'b0;
        2'b01:   misalign_s = bus.addr[0];
        2'b10:   misalign_s = (bus.addr[1:0] != 2'b00);
        default: misalign_s = 1'b1;
      endcase
      oob_s = (bus.addr[31:AW+2] != {(30-AW){1'b0}});
    end else begin
      misalign_s = 1'b0;
      oob_s      = 1'b0;
    end
  end

  assign rejected_s = misalign_s | oob_s;
  assign store_s    = req_s & bus.mem_write & ~rejected_s;

  // Load lane selection and sign/zero extension.
  always_comb begin
    rdata_s = 32'h0000_0000;
    byte_s  = 8'h00;
    half_s  = 16'h0000;
    ext_s   = 1'b0;
    case (lane_s)
      2'b00:   byte_s = rd_word_s[7:0];
      2'b01:   byte_s = rd_word_s[15:8];
      2'b10:   byte_s = rd_word_s[23:16];
      default: byte_s = rd_word_s[31:24];
    endcase
    if (bus.addr[1]) begin
      half_s = rd_word_s[31:16];
    end else begin
      half_s = rd_word_s[15:0];
    end
    if (req_s && bus.mem_read && !rejected_s) begin
      case (bus.size)
        2'b00: begin
          ext_s   = ~bus.ld_uns & byte_s[7];
          rdata_s = {{24{ext_s}}, byte_s};
        end
        2'b01: begin
          ext_s   = ~bus.ld_uns & half_s[15];
          rdata_s = {{16{ext_s}}, half_s};
        end
        2'b10:   rdata_s = rd_word_s;
        default: rdata_s = 32'h0000_0000;
      endcase
    end else begin
      rdata_s = 32'h0000_0000;
    end
  end

  // Store byte enables; store data replicated so every lane sees its slice.
  always_comb begin
    be_s = 4'b0000;
    wd_s = bus.wdata;
    case (bus.size)
      2'b00: begin
        be_s = 4'b0001 << lane_s;
        wd_s = {4{bus.wdata[7:0]}};
      end
      2'b01: begin
        be_s = bus.addr[1] ? 4'b1100 : 4'b0011;
        wd_s = {2{bus.wdata[15:0]}};
      end
      2'b10: begin
        be_s = 4'b1111;
        wd_s = bus.wdata;
      end
      default: begin
        be_s = 4'b0000;
        wd_s = bus.wdata;
      end
    endcase
  end

  // Fill FSM next state and sticky error accumulation.
  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    err_sticky_d = err_sticky_q | rejected_s;
    case (state_q)
      ST_CLEAR: begin
        clr_ptr_d = clr_ptr_q + {{(AW-1){1'b0}}, 1'b1};
        if (clr_ptr_q == LAST_IDX) begin
          state_d = ST_READY;
        end else begin
          state_d = ST_CLEAR;
        end
      end
      ST_READY: state_d = ST_READY;
      default:  state_d = ST_CLEAR;
    endcase
  end

  // FSM, fill pointer and sticky error registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_CLEAR;
      clr_ptr_q    <= {AW{1'b0}};
      err_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Array writes: zero-fill while clearing, byte-enabled stores when ready.
  always_ff @(posedge clk) begin
    if (state_q == ST_CLEAR) begin
      mem_q[clr_ptr_q] <= 32'h0000_0000;
    end else if (store_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          mem_q[idx_s][8*i +: 8] <= wd_s[8*i +: 8];
        end
      end
    end
  end

  assign bus.rdata      = rdata_s;
  assign bus.busy       = (state_q == ST_CLEAR);
  assign bus.misalign   = misalign_s;
  assign bus.oob        = oob_s;
  assign bus.err_sticky = err_sticky_q;

endmodule

// File: tb/tb_data_mem_unit.sv
// Self-checking bench for data_mem_unit: scoreboard queue of expected load
// data, one task per feature.
module tb_data_mem_unit;

  logic clk;
  logic reset;
  int   vec_cnt;
  int   err_cnt;
  logic [31:0] exp_q [$];

  data_mem_unit_if bus ();

  data_mem_unit #(.DEPTH_WORDS(256), .AW(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_bus(input logic [31:0] a, input logic [31:0] wd, input logic rd,
                         input logic wr, input logic [1:0] sz, input logic uns);
    @(negedge clk);
    bus.addr = a; bus.wdata = wd; bus.mem_read = rd; bus.mem_write = wr;
    bus.size = sz; bus.ld_uns = uns;
    #1;
  endtask

  task automatic go_idle();
    bus.mem_read = 1'b0; bus.mem_write = 1'b0; bus.size = 2'b10;
    bus.ld_uns = 1'b0; bus.addr = 32'h0; bus.wdata = 32'h0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] wd, input logic [1:0] sz);
    set_bus(a, wd, 1'b0, 1'b1, sz, 1'b0);
    @(posedge clk); #1;
    go_idle();
  endtask

  // Load through the scoreboard: expected pushed at drive, popped at compare.
  task automatic do_load(input string nm, input logic [31:0] a, input logic [1:0] sz,
                         input logic uns, input logic [31:0] expv);
    logic [31:0] e;
    set_bus(a, 32'h0, 1'b1, 1'b0, sz, uns);
    exp_q.push_back(expv);
    e = exp_q.pop_front();
    vec_cnt++;
    if (bus.rdata !== e) begin
      err_cnt++;
      $display("FAIL %s: rdata=%h expected %h", nm, bus.rdata, e);
    end
    go_idle();
  endtask

  task automatic wait_fill(input string nm, input int expected);
    int n;
    n = 0;
    while (bus.busy === 1'b1 && n < 1000) begin
      @(posedge clk); #1;
      n++;
    end
    vec_cnt++;
    if (n != expected) begin
      err_cnt++;
      $display("FAIL %s: busy cycles=%0d expected %0d", nm, n, expected);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    set_bus(32'h0000_0400, 32'h0, 1'b1, 1'b1, 2'b11, 1'b0);
    vec_cnt++;
    if ({bus.busy, bus.misalign, bus.oob, bus.err_sticky} !== 4'b1000 || bus.rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL reset_state: busy/mis/oob/err=%b rdata=%h expected 1000 / 0",
               {bus.busy, bus.misalign, bus.oob, bus.err_sticky}, bus.rdata);
    end
  endtask

  task automatic test_fill();
    @(negedge clk);
    reset = 1'b0;
    #1;
    // bad request during fill must be ignored
    vec_cnt++;
    if ({bus.misalign, bus.oob} !== 2'b00 || bus.rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL clear_ignore: mis/oob=%b rdata=%h expected 00 / 0",
               {bus.misalign, bus.oob}, bus.rdata);
    end
    @(posedge clk); #1;
    go_idle();
    wait_fill("fill_len", 255);
    vec_cnt++;
    if (bus.err_sticky !== 1'b0) begin
      err_cnt++;
      $display("FAIL fill_err: err_sticky=%b expected 0", bus.err_sticky);
    end
    do_load("lw_3fc", 32'h0000_03FC, 2'b10, 1'b0, 32'h0);
  endtask

  task automatic test_load_ext();
    logic [31:0] ta [9];
    logic [1:0]  ts [9];
    logic        tu [9];
    logic [31:0] te [9];
    ta = '{32'h10, 32'h10, 32'h11, 32'h12, 32'h13, 32'h13, 32'h12, 32'h12, 32'h10};
    ts = '{2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 2'b01, 2'b01, 2'b01};
    tu = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    te = '{32'h80FF7F01, 32'h00000001, 32'h0000007F, 32'hFFFFFFFF, 32'h00000080,
           32'hFFFFFF80, 32'hFFFF80FF, 32'h000080FF, 32'h00007F01};
    do_store(32'h10, 32'h80FF7F01, 2'b10);
    for (int i = 0; i < 9; i++) begin
      do_load($sformatf("ld_ext%0d", i), ta[i], ts[i], tu[i], te[i]);
    end
    set_bus(32'h10, 32'h0, 1'b0, 1'b0, 2'b10, 1'b0);
    vec_cnt++;
    if (bus.rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL no_read: rdata=%h expected 00000000", bus.rdata);
    end
    go_idle();
  endtask

  task automatic test_partial_store();
    do_store(32'h21, 32'hDEADBEAB, 2'b00);
    do_load("sb_21", 32'h20, 2'b10, 1'b0, 32'h0000AB00);
    do_store(32'h22, 32'hFFFF1234, 2'b01);
    do_load("sh_22", 32'h20, 2'b10, 1'b0, 32'h1234AB00);
  endtask

  task automatic test_misalign();
    do_store(32'h04, 32'h5555AAAA, 2'b10);
    vec_cnt++;
    if (bus.err_sticky !== 1'b0) begin
      err_cnt++;
      $display("FAIL err_pre: err_sticky=%b expected 0", bus.err_sticky);
    end
    set_bus(32'h06, 32'h11111111, 1'b0, 1'b1, 2'b10, 1'b0);
    vec_cnt++;
    if ({bus.misalign, bus.oob} !== 2'b10) begin
      err_cnt++;
      $display("FAIL sw_06_flags: mis/oob=%b expected 10", {bus.misalign, bus.oob});
    end
    @(posedge clk); #1;
    go_idle();
    vec_cnt++;
    if (bus.err_sticky !== 1'b1) begin
      err_cnt++;
      $display("FAIL err_set: err_sticky=%b expected 1", bus.err_sticky);
    end
    do_load("sw_06_nowrite", 32'h04, 2'b10, 1'b0, 32'h5555AAAA);
    set_bus(32'h03, 32'h0, 1'b1, 1'b0, 2'b01, 1'b0);
    vec_cnt++;
    if (bus.misalign !== 1'b1 || bus.rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL lh_03: mis=%b rdata=%h expected 1 / 0", bus.misalign, bus.rdata);
    end
    set_bus(32'h08, 32'h0, 1'b1, 1'b0, 2'b11, 1'b0);
    vec_cnt++;
    if (bus.misalign !== 1'b1) begin
      err_cnt++;
      $display("FAIL size11: mis=%b expected 1", bus.misalign);
    end
    go_idle();
    do_load("lh_06_ok", 32'h06, 2'b01, 1'b0, 32'h00005555);
  endtask

  task automatic test_oob();
    do_store(32'h00, 32'h01020304, 2'b10);
    set_bus(32'h400, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    vec_cnt++;
    if ({bus.oob, bus.misalign} !== 2'b10 || bus.rdata !== 32'h0) begin
      err_cnt++;
      $display("FAIL lw_400: oob/mis=%b rdata=%h expected 10 / 0",
               {bus.oob, bus.misalign}, bus.rdata);
    end
    go_idle();
    do_store(32'h400, 32'hCAFEF00D, 2'b10);
    do_load("oob_nowrite", 32'h00, 2'b10, 1'b0, 32'h01020304);
    set_bus(32'h3FC, 32'h0, 1'b1, 1'b0, 2'b10, 1'b0);
    vec_cnt++;
    if (bus.oob !== 1'b0) begin
      err_cnt++;
      $display("FAIL lw_3fc_oob: oob=%b expected 0", bus.oob);
    end
    go_idle();
  endtask

  task automatic test_rw_same();
    do_store(32'h30, 32'hAAAA0001, 2'b10);
    set_bus(32'h30, 32'h12345678, 1'b1, 1'b1, 2'b10, 1'b0);
    exp_q.push_back(32'hAAAA0001);
    vec_cnt++;
    if (bus.rdata !== exp_q.pop_front()) begin
      err_cnt++;
      $display("FAIL rw_pre: rdata=%h expected aaaa0001", bus.rdata);
    end
    @(posedge clk); #1;
    go_idle();
    do_load("rw_post", 32'h30, 2'b10, 1'b0, 32'h12345678);
  endtask

  task automatic test_reset_midfill();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    vec_cnt++;
    if (bus.busy !== 1'b1 || bus.err_sticky !== 1'b0) begin
      err_cnt++;
      $display("FAIL midfill_rst: busy=%b err=%b expected 1 / 0", bus.busy, bus.err_sticky);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    wait_fill("refill_len", 256);
    vec_cnt++;
    if (bus.err_sticky !== 1'b0) begin
      err_cnt++;
      $display("FAIL refill_err: err_sticky=%b expected 0", bus.err_sticky);
    end
    for (int i = 0; i < 256; i++) begin
      do_load($sformatf("zero_w%0d", i), 32'(i * 4), 2'b10, 1'b0, 32'h0);
    end
  endtask

  initial begin
    vec_cnt = 0;
    err_cnt = 0;
    go_idle();
    test_reset();
    test_fill();
    test_load_ext();
    test_partial_store();
    test_misalign();
    test_oob();
    test_rw_same();
    test_reset_midfill();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
